// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller: operand-select
// codes used by the per-operand match logic and the top level.
package fwd_hazard_ctrl_pkg;

    typedef logic [1:0] fwdSel_t;

    localparam fwdSel_t FWD_REG   = 2'b00;
    localparam fwdSel_t FWD_EXMEM = 2'b10;
    localparam fwdSel_t FWD_MEMWB = 2'b01;

endpackage

// File: rtl/fwd_src_match.sv
// Forward-select for one EX operand, derived from the EX/MEM and MEM/WB
// shadow tags. A load sitting in MEM never forwards from EX/MEM.
module fwd_src_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic              exValid,
    input  logic              srcUsed,
    input  logic [REG_AW-1:0] src,
    input  logic              memValid,
    input  logic              memRegWrite,
    input  logic              memMemToReg,
    input  logic [REG_AW-1:0] memRd,
    input  logic              wbValid,
    input  logic              wbRegWrite,
    input  logic [REG_AW-1:0] wbRd,
    output fwdSel_t           sel
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic memHit_s;
    logic wbHit_s;

    assign memHit_s = memValid & memRegWrite & (memRd != REG_ZERO) & (memRd == src);
    assign wbHit_s  = wbValid & wbRegWrite & (wbRd != REG_ZERO) & (wbRd == src);

    // EX/MEM wins over MEM/WB when both stages write the source register
    always_comb begin
        sel = FWD_REG;
        if (!exValid || !srcUsed) begin
            sel = FWD_REG;
        end else if (memHit_s && !memMemToReg) begin
            sel = FWD_EXMEM;
        end else if (wbHit_s) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REG;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline; keeps
// shadow EX/MEM/WB tags advanced by the same stall, flush and freeze rules.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW    = 4,
    parameter int NUM_SRC   = 2,
    parameter int STORE_SRC = 1,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memtoreg,
    input  logic                      id_memwrite,
    input  logic                      flush_id,
    input  logic                      mem_busy,
    output logic                      stall_id,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      fwd_mem,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic                      exV_r;
    logic [NUM_SRC*REG_AW-1:0] exSrc_r;
    logic [NUM_SRC-1:0]        exUsed_r;
    logic [REG_AW-1:0]         exRd_r;
    logic                      exRw_r;
    logic                      exM2r_r;
    logic                      exMw_r;

    logic                      memV_r;
    logic [REG_AW-1:0]         memRd_r;
    logic                      memRw_r;
    logic                      memM2r_r;
    logic                      memMw_r;
    logic [REG_AW-1:0]         memStSrc_r;

    logic                      wbV_r;
    logic [REG_AW-1:0]         wbRd_r;
    logic                      wbRw_r;
    logic                      wbM2r_r;

    logic [CNT_W-1:0]          stallCnt_r;
    logic [NUM_SRC-1:0]        srcHazard_s;
    logic                      loadUse_s;

    // Per-source load-use check; store data from a load is covered by fwd_mem
    always_comb begin
        srcHazard_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            srcHazard_s[i] = id_valid & id_src_used[i] & exV_r & exRw_r
                           & (exRd_r != REG_ZERO)
                           & (exRd_r == id_src[i*REG_AW +: REG_AW])
                           & ~(id_memwrite & (i == STORE_SRC));
        end
        loadUse_s = exM2r_r & (|srcHazard_s);
    end

    assign stall_id  = loadUse_s | mem_busy;
    assign stall_cnt = stallCnt_r;
    assign fwd_mem   = memV_r & memMw_r & wbV_r & wbRw_r & wbM2r_r
                     & (wbRd_r != REG_ZERO) & (wbRd_r == memStSrc_r);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_match #(.REG_AW(REG_AW)) u_match (
            .exValid     (exV_r),
            .srcUsed     (exUsed_r[g]),
            .src         (exSrc_r[g*REG_AW +: REG_AW]),
            .memValid    (memV_r),
            .memRegWrite (memRw_r),
            .memMemToReg (memM2r_r),
            .memRd       (memRd_r),
            .wbValid     (wbV_r),
            .wbRegWrite  (wbRw_r),
            .wbRd        (wbRd_r),
            .sel         (fwd_sel[2*g +: 2])
        );
    end

    // Shadow pipeline tags: freeze on mem_busy, bubble into EX on load-use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exV_r      <= 1'b0;
            exSrc_r    <= {(NUM_SRC*REG_AW){1'b0}};
            exUsed_r   <= {NUM_SRC{1'b0}};
            exRd_r     <= REG_ZERO;
            exRw_r     <= 1'b0;
            exM2r_r    <= 1'b0;
            exMw_r     <= 1'b0;
            memV_r     <= 1'b0;
            memRd_r    <= REG_ZERO;
            memRw_r    <= 1'b0;
            memM2r_r   <= 1'b0;
            memMw_r    <= 1'b0;
            memStSrc_r <= REG_ZERO;
            wbV_r      <= 1'b0;
            wbRd_r     <= REG_ZERO;
            wbRw_r     <= 1'b0;
            wbM2r_r    <= 1'b0;
        end else if (!mem_busy) begin
            memV_r     <= exV_r;
            memRd_r    <= exRd_r;
            memRw_r    <= exRw_r;
            memM2r_r   <= exM2r_r;
            memMw_r    <= exMw_r;
            memStSrc_r <= exSrc_r[STORE_SRC*REG_AW +: REG_AW];
            wbV_r      <= memV_r;
            wbRd_r     <= memRd_r;
            wbRw_r     <= memRw_r;
            wbM2r_r    <= memM2r_r;
            if (loadUse_s) begin
                exV_r <= 1'b0;
            end else begin
                exV_r    <= id_valid & ~flush_id;
                exSrc_r  <= id_src;
                exUsed_r <= id_src_used;
                exRd_r   <= id_rd;
                exRw_r   <= id_regwrite;
                exM2r_r  <= id_memtoreg;
                exMw_r   <= id_memwrite;
            end
        end
    end

    // Saturating count of cycles actually lost to load-use stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_r <= {CNT_W{1'b0}};
        end else if (loadUse_s && !mem_busy && (stallCnt_r != CNT_MAX)) begin
            stallCnt_r <= stallCnt_r + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench: directed vector table, reset-during-stall sequence, and
// randomized traffic against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [7:0]  id_src;
    logic [1:0]  id_src_used;
    logic [3:0]  id_rd;
    logic        id_regwrite;
    logic        id_memtoreg;
    logic        id_memwrite;
    logic        flush_id;
    logic        mem_busy;
    logic        stall_id, stall_id_sat;
    logic [3:0]  fwd_sel, fwd_sel_sat;
    logic        fwd_mem, fwd_mem_sat;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt_sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(4), .NUM_SRC(2), .STORE_SRC(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .flush_id(flush_id),
        .mem_busy(mem_busy), .stall_id(stall_id), .fwd_sel(fwd_sel),
        .fwd_mem(fwd_mem), .stall_cnt(stall_cnt)
    );

    // Narrow counter instance so saturation is reachable
    fwd_hazard_ctrl #(.REG_AW(4), .NUM_SRC(2), .STORE_SRC(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .flush_id(flush_id),
        .mem_busy(mem_busy), .stall_id(stall_id_sat), .fwd_sel(fwd_sel_sat),
        .fwd_mem(fwd_mem_sat), .stall_cnt(stall_cnt_sat)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] rd;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [1:0] used;
        logic       rw;
        logic       m2r;
        logic       mw;
    } instr_t;

    typedef struct {
        instr_t      id;
        logic        flush;
        logic        busy;
        logic        eStall;
        logic [3:0]  eSel;
        logic        eMem;
        logic [15:0] eCnt;
    } vec_t;

    function automatic instr_t ins(input logic v, input logic [3:0] rd, s0, s1,
                                   input logic [1:0] used, input logic rw, m2r, mw);
        instr_t r;
        r.v = v; r.rd = rd; r.s0 = s0; r.s1 = s1; r.used = used;
        r.rw = rw; r.m2r = m2r; r.mw = mw;
        return r;
    endfunction

    function automatic vec_t mk(input instr_t id, input logic flush, busy, eStall,
                                input logic [3:0] eSel, input logic eMem,
                                input logic [15:0] eCnt);
        vec_t t;
        t.id = id; t.flush = flush; t.busy = busy; t.eStall = eStall;
        t.eSel = eSel; t.eMem = eMem; t.eCnt = eCnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t id, input logic flush, input logic busy);
        @(negedge clk);
        id_valid    = id.v;
        id_src      = {id.s1, id.s0};
        id_src_used = id.used;
        id_rd       = id.rd;
        id_regwrite = id.rw;
        id_memtoreg = id.m2r;
        id_memwrite = id.mw;
        flush_id    = flush;
        mem_busy    = busy;
        #1;
    endtask

    // Reference model: mp[0]=EX, mp[1]=MEM, mp[2]=WB, each a whole instruction
    instr_t      mp [3];
    int unsigned mcnt;

    function automatic logic mhit(input instr_t s, input logic [3:0] r);
        return s.v && s.rw && (s.rd != 4'd0) && (s.rd == r);
    endfunction

    function automatic logic [1:0] msel(input logic [3:0] r, input logic u);
        if (!mp[0].v || !u) return 2'b00;
        if (mhit(mp[1], r) && !mp[1].m2r) return 2'b10;
        if (mhit(mp[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic mlu(input instr_t id);
        return mp[0].m2r && id.v &&
               ((id.used[0] && mhit(mp[0], id.s0)) ||
                (id.used[1] && mhit(mp[0], id.s1) && !id.mw));
    endfunction

    task automatic model_step(input instr_t id, input logic flush, input logic busy);
        logic lu;
        lu = mlu(id);
        if (!busy) begin
            mp[2] = mp[1];
            mp[1] = mp[0];
            if (lu) begin
                mp[0].v = 1'b0;
                mcnt++;
            end else begin
                mp[0]   = id;
                mp[0].v = id.v & ~flush;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(ins(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) mp[k] = '0;
        mcnt = 0;
    endtask

    vec_t   tbl[$];
    instr_t nop, ld, use_r2, ri;
    logic   rf, rb;
    logic [1:0] eSat;

    initial begin
        nop = ins(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        id_valid = 1'b0; id_src = 8'd0; id_src_used = 2'b00; id_rd = 4'd0;
        id_regwrite = 1'b0; id_memtoreg = 1'b0; id_memwrite = 1'b0;
        flush_id = 1'b0; mem_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // id (v,rd,s0,s1,used,rw,m2r,mw), flush, busy, stall, fwd_sel, fwd_mem, cnt
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd3, 4'd1, 4'd2, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd4, 4'd3, 4'd5, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd9, 4'd1, 4'd1, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd6, 4'd9, 4'd9, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd10, 4'd1, 4'd2, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd10, 4'd2, 4'd2, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd11, 4'd10, 4'd10, 2'b01, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd2, 4'd1, 4'd0, 2'b01, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd7, 4'd2, 4'd1, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 16'd0));
        tbl.push_back(mk(ins(1'b1, 4'd7, 4'd2, 4'd1, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd1));
        tbl.push_back(mk(ins(1'b1, 4'd5, 4'd1, 4'd0, 2'b01, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(ins(1'b1, 4'd0, 4'd1, 4'd5, 2'b11, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 16'd1));
        tbl.push_back(mk(ins(1'b1, 4'd0, 4'd1, 4'd0, 2'b01, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(ins(1'b1, 4'd1, 4'd0, 4'd0, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(ins(1'b1, 4'd12, 4'd1, 4'd1, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(ins(1'b1, 4'd13, 4'd12, 4'd12, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 16'd1));
        tbl.push_back(mk(ins(1'b1, 4'd14, 4'd1, 4'd1, 2'b11, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(ins(1'b1, 4'd15, 4'd1, 4'd1, 2'b11, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(ins(1'b1, 4'd1, 4'd15, 4'd15, 2'b11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));
        tbl.push_back(mk(nop, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1));

        foreach (tbl[k]) begin
            drive(tbl[k].id, tbl[k].flush, tbl[k].busy);
            check($sformatf("row%0d stall_id", k), 32'(stall_id), 32'(tbl[k].eStall));
            check($sformatf("row%0d fwd_sel", k), 32'(fwd_sel), 32'(tbl[k].eSel));
            check($sformatf("row%0d fwd_mem", k), 32'(fwd_mem), 32'(tbl[k].eMem));
            check($sformatf("row%0d stall_cnt", k), 32'(stall_cnt), 32'(tbl[k].eCnt));
        end

        // Asynchronous reset while a load-use stall is being signalled
        ld     = ins(1'b1, 4'd2, 4'd1, 4'd0, 2'b01, 1'b1, 1'b1, 1'b0);
        use_r2 = ins(1'b1, 4'd7, 4'd2, 4'd1, 2'b11, 1'b1, 1'b0, 1'b0);
        drive(ld, 1'b0, 1'b0);
        drive(use_r2, 1'b0, 1'b0);
        check("pre-reset stall_id", 32'(stall_id), 32'd1);
        check("pre-reset stall_cnt", 32'(stall_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid-stall reset stall_id", 32'(stall_id), 32'd0);
        check("mid-stall reset stall_cnt", 32'(stall_cnt), 32'd0);
        check("mid-stall reset fwd_sel", 32'(fwd_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(use_r2, 1'b0, 1'b0);
        check("post-reset stall_id", 32'(stall_id), 32'd0);
        check("post-reset stall_cnt", 32'(stall_cnt), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int kind;
            kind    = int'($urandom_range(3, 0));
            ri.v    = ($urandom_range(7, 0) != 0);
            ri.rd   = 4'($urandom_range(3, 0));
            ri.s0   = 4'($urandom_range(3, 0));
            ri.s1   = 4'($urandom_range(3, 0));
            ri.used = 2'($urandom_range(3, 0));
            case (kind)
                0:       begin ri.rw = 1'b1; ri.m2r = 1'b0; ri.mw = 1'b0; end
                1:       begin ri.rw = 1'b1; ri.m2r = 1'b1; ri.mw = 1'b0; end
                2:       begin ri.rw = 1'b0; ri.m2r = 1'b0; ri.mw = 1'b1; end
                default: begin ri.rw = 1'($urandom); ri.m2r = 1'($urandom); ri.mw = 1'($urandom); end
            endcase
            rf = ($urandom_range(7, 0) == 0);
            rb = ($urandom_range(7, 0) == 0);
            drive(ri, rf, rb);
            eSat = (mcnt > 3) ? 2'd3 : 2'(mcnt);
            check($sformatf("rnd%0d stall_id", n), 32'(stall_id), 32'(mlu(ri) | rb));
            check($sformatf("rnd%0d fwd_sel", n), 32'(fwd_sel),
                  32'({msel(mp[0].s1, mp[0].used[1]), msel(mp[0].s0, mp[0].used[0])}));
            check($sformatf("rnd%0d fwd_mem", n), 32'(fwd_mem),
                  32'(mp[1].v && mp[1].mw && mhit(mp[2], mp[1].s1) && mp[2].m2r));
            check($sformatf("rnd%0d stall_cnt", n), 32'(stall_cnt), mcnt);
            check($sformatf("rnd%0d sat stall_cnt", n), 32'(stall_cnt_sat), 32'(eSat));
            model_step(ri, rf, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and hazard controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- It keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB register tags, advanced by the same stall, flush and freeze rules as the datapath.
- From those tags it generates EX-operand forward selects, the MEM-to-MEM store-data forward, and the load-use stall.
- It also counts load-use stall cycles for performance analysis.

Parameters:
- REG_AW, 4: register-ID width.
- NUM_SRC, 2: source operands per instruction.
- STORE_SRC, 1: index of the source that carries store data.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  instruction in ID is real (not a bubble).
- id_src  in  NUM_SRC*REG_AW  source register IDs; src0 in the LSBs.
- id_src_used  in  NUM_SRC  bit i set = source i is actually read.
- id_rd  in  REG_AW  destination register.
- id_regwrite  in  1  instruction writes the register file.
- id_memtoreg  in  1  instruction is a load.
- id_memwrite  in  1  instruction is a store.
- flush_id  in  1  squash the ID instruction; it enters EX as a bubble.
- mem_busy  in  1  data memory not done; freezes the entire pipeline.
- stall_id  out  1  hold PC and IF/ID; insert a bubble into EX.
- fwd_sel  out  NUM_SRC*2  per EX operand: 00 register file, 10 EX/MEM, 01 MEM/WB.
- fwd_mem  out  1  select the MEM/WB load data as store data in MEM.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Shadow stages:
  - EX holds {v, src[], used[], rd, rw, m2r, mw}.
  - MEM holds {v, rd, rw, m2r, mw, st_src}.
  - WB holds {v, rd, rw, m2r}.
- Reset (async, any time, including mid-stall): all v=0, stall_cnt=0. All outputs then evaluate to 0: stall_id=0, fwd_sel=0, fwd_mem=0.
- Stage advance, one rule per posedge, in priority order:
  1. mem_busy=1: all shadow stages hold.
  2. Else stall_id=1: EX.v<=0, MEM<=EX, WB<=MEM.
  3. Else: EX<=ID with EX.v = id_valid & ~flush_id, MEM<=EX, WB<=MEM.
- hit(stage, r): stage.v & stage.rw & (stage.rd != 0) & (stage.rd == r). Register 0 is never a forwarding or hazard source.
- fwd_sel[i], combinational from shadow state only; 00 whenever EX.used[i]=0 or EX.v=0:
  - 10 if hit(MEM, EX.src[i]) & ~MEM.m2r.
  - Else 01 if hit(WB, EX.src[i]).
  - Else 00.
  - EX/MEM has priority when both match.
- fwd_mem = MEM.v & MEM.mw & hit(WB, MEM.st_src) & WB.m2r.
- Load-use hazard lu, combinational:
  - lu = EX.m2r & OR over i of (id_valid & id_src_used[i] & hit(EX, id_src[i]) & ~exempt_i).
  - exempt_i = id_memwrite & (i == STORE_SRC). A store whose data comes from the load is covered by fwd_mem, so it does not stall.
- stall_id = lu | mem_busy.
- stall_cnt increments on each posedge where lu=1 and mem_busy=0. It saturates at all-ones; there is no wrap.
- A load followed by a dependent instruction stalls exactly 1 cycle. The next cycle the load is in MEM with m2r=1, so the EX/MEM forward is suppressed and the MEM/WB forward is taken on the following cycle; no EX/MEM load forward ever occurs.
- flush_id together with lu: the bubble is inserted regardless. The held ID instruction is still presented next cycle; the core is responsible for dropping it.
- mem_busy together with flush_id: the freeze wins and the flush is ignored that cycle. The core must reassert flush_id after the freeze.
- All outputs are combinational functions of the shadow registers and ID inputs; there are no combinational paths from mem_busy to fwd_sel or fwd_mem.

Decomposition:
- Shared package/include fwd_defs:
  - FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
  - Stage-tag field widths derived from REG_AW.
- One sub-module, fwd_src_match (REG_AW param). It computes the 2-bit select for a single operand from the MEM/WB tags and is instantiated NUM_SRC times in a generate loop.

Test Plan:
- add r3 then add r4,r3,r5 back-to-back -> in the second cycle fwd_sel[1:0]=10, no stall.
- add r3; nop; sub r6,r3,r3 -> fwd_sel=0101 (both operands MEM/WB).
- add r3 (WB) and add r3 (MEM) both in flight, consumer reads r3 -> 10 (priority).
- lw r2 then add r7,r2,r1:
  - stall_id=1 for exactly 1 cycle, stall_cnt 0->1.
  - Next cycle fwd_sel[1:0]=01.
- lw r2 then sw r2 -> no stall; fwd_mem=1 when the store is in MEM.
- lw r0 then add r1,r0,r0 -> no stall, fwd_sel=00.
- mem_busy held 3 cycles mid-sequence -> shadow tags and outputs frozen, stall_id=1, stall_cnt unchanged.
- rst_n low during a load-use stall -> stall_id=0 immediately, stall_cnt=0.
